secded_pipe_codec: RTL and testbench

SECDED_PIPE_CODEC -- requirements
Module: secded_pipe_codec

---
 rtl/secded_pkg.sv | 43 ++++
 rtl/secded_pipe_codec_if.sv | 27 ++
 rtl/secded_chkgen.sv | 30 +++
 rtl/secded_pipe_codec.sv | 182 ++++++++++++++++++
 tb/tb_secded_pipe_codec.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED pipelined codec: code geometry helpers,
// mode encodings and the decode error classes.
package secded_pkg;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;

   typedef enum logic [2:0] {
      CLEAN   = 3'd0,
      CE_DATA = 3'd1,
      CE_CHK  = 3'd2,
      CE_PAR  = 3'd3,
      UE      = 3'd4
   } err_class_e;

   // Hamming bits r with 2^r >= data_w + r + 1, plus one overall parity bit.
   function automatic int chk_w_f(input int data_w);
      int r;
      r = 1;
      while ((32'sd1 << r) < (data_w + r + 32'sd1)) begin
         r = r + 1;
      end
      return r + 32'sd1;
   endfunction

   // Codeword position of data bit idx: the idx-th non-power-of-two from 3 up.
   function automatic int data_pos_f(input int idx);
      int res;
      int cnt;
      res = 0;
      cnt = 0;
      for (int p = 3; p < 256; p++) begin
         if ((p & (p - 32'sd1)) != 32'sd0) begin
            if (cnt == idx) begin
               res = p;
            end
            cnt = cnt + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/secded_pipe_codec_if.sv
// Beat-level handshake bundle between a producer/consumer and the codec.
interface secded_pipe_codec_if #(
   parameter int DATA_W = 64,
   parameter int CHK_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic              in_mode;
   logic [DATA_W-1:0] in_data;
   logic [CHK_W-1:0]  in_chk;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CHK_W-1:0]  out_chk;
   logic              out_ce;
   logic              out_ue;

   modport master (
      output in_valid, in_mode, in_data, in_chk, out_ready,
      input  in_ready, out_valid, out_data, out_chk, out_ce, out_ue
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_chk, out_ready,
      output in_ready, out_valid, out_data, out_chk, out_ce, out_ue
   );
endinterface

// File: rtl/secded_chkgen.sv
// Combinational Hamming check generator shared by the encode and decode paths:
// CHK_W-1 Hamming bits over the data word plus overall parity of data and Hamming bits.
module secded_chkgen
   import secded_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CHK_W  = 8
) (
   input  logic [DATA_W-1:0] data,
   output logic [CHK_W-2:0]  ham,
   output logic              par
);
   localparam int HW = CHK_W - 1;

   logic [HW-1:0][DATA_W-1:0] sel_s;

   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      localparam int POS_I = data_pos_f(i);
      for (genvar k = 0; k < HW; k++) begin : g_chk
         assign sel_s[k][i] = data[i] & POS_I[k];
      end
   end

   for (genvar k = 0; k < HW; k++) begin : g_ham
      assign ham[k] = ^sel_s[k];
   end

   assign par = (^data) ^ (^ham);

endmodule

// File: rtl/secded_pipe_codec.sv
// Two-stage SECDED encoder/decoder with valid/ready flow control and
// saturating corrected/uncorrectable error counters.
module secded_pipe_codec
   import secded_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CHK_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   secded_pipe_codec_if.slave bus,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   ce_cnt,
   output logic [CNT_W-1:0]   ue_cnt
);
   localparam int               HW         = CHK_W - 1;
   localparam int               MAX_POS_I  = data_pos_f(DATA_W - 1);
   localparam logic [HW-1:0]    MAX_POS_C  = MAX_POS_I[HW-1:0];
   localparam logic [HW-1:0]    SYN_ZERO_C = {HW{1'b0}};
   localparam logic [HW-1:0]    SYN_ONE_C  = {{(HW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [HW-1:0]     ham_s;
   logic              par_s;
   logic [CHK_W-1:0]  s1_chk_nxt_s;
   logic              s1_valid_r;
   logic              s1_mode_r;
   logic [DATA_W-1:0] s1_data_r;
   logic [CHK_W-1:0]  s1_chk_r;
   logic              s2_free_s;
   logic              s1_adv_s;
   logic              in_ready_s;
   logic              in_fire_s;
   logic              out_fire_s;
   logic [HW-1:0]     syn_s;
   logic [DATA_W-1:0] flip_s;
   logic [DATA_W-1:0] corr_data_s;
   err_class_e        cls_s;
   logic              ce_s;
   logic              ue_s;
   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic [CHK_W-1:0]  out_chk_r;
   logic              out_ce_r;
   logic              out_ue_r;
   logic [CNT_W-1:0]  ce_cnt_r;
   logic [CNT_W-1:0]  ue_cnt_r;

   secded_chkgen #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_chkgen (
      .data (bus.in_data),
      .ham  (ham_s),
      .par  (par_s)
   );

   assign s2_free_s  = !out_valid_r || bus.out_ready;
   assign s1_adv_s   = s1_valid_r && s2_free_s;
   assign in_ready_s = !s1_valid_r || s1_adv_s;
   assign in_fire_s  = bus.in_valid && in_ready_s;
   assign out_fire_s = out_valid_r && bus.out_ready;

   // Encode keeps {parity, hamming}; decode folds the received check into {p, s}.
   always_comb begin
      s1_chk_nxt_s = {par_s, ham_s};
      if (bus.in_mode == DEC) begin
         s1_chk_nxt_s = {par_s ^ (^ham_s) ^ (^bus.in_chk), ham_s ^ bus.in_chk[HW-1:0]};
      end else begin
         s1_chk_nxt_s = {par_s, ham_s};
      end
   end

   // Stage 1: capture the accepted beat with its check or syndrome.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_mode_r  <= 1'b0;
         s1_data_r  <= {DATA_W{1'b0}};
         s1_chk_r   <= {CHK_W{1'b0}};
      end else if (in_fire_s) begin
         s1_valid_r <= 1'b1;
         s1_mode_r  <= bus.in_mode;
         s1_data_r  <= bus.in_data;
         s1_chk_r   <= s1_chk_nxt_s;
      end else if (s1_adv_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   assign syn_s = s1_chk_r[HW-1:0];

   for (genvar i = 0; i < DATA_W; i++) begin : g_flip
      localparam int            POS_I = data_pos_f(i);
      localparam logic [HW-1:0] POS_C = POS_I[HW-1:0];
      assign flip_s[i] = (syn_s == POS_C);
   end

   // Classify the syndrome; a nonzero power of two points at a check bit.
   always_comb begin
      cls_s = CLEAN;
      if (s1_mode_r == ENC) begin
         cls_s = CLEAN;
      end else if (!s1_chk_r[HW]) begin
         cls_s = (syn_s == SYN_ZERO_C) ? CLEAN : UE;
      end else if (syn_s == SYN_ZERO_C) begin
         cls_s = CE_PAR;
      end else if ((syn_s & (syn_s - SYN_ONE_C)) == SYN_ZERO_C) begin
         cls_s = CE_CHK;
      end else if (syn_s > MAX_POS_C) begin
         cls_s = UE;
      end else begin
         cls_s = CE_DATA;
      end
   end

   // Derive flags and corrected data from the error class.
   always_comb begin
      ce_s        = 1'b0;
      ue_s        = 1'b0;
      corr_data_s = s1_data_r;
      case (cls_s)
         CE_DATA: begin
            ce_s        = 1'b1;
            corr_data_s = s1_data_r ^ flip_s;
         end
         CE_CHK, CE_PAR: ce_s = 1'b1;
         UE:             ue_s = 1'b1;
         CLEAN:          ce_s = 1'b0;
         default: begin
            ce_s = 1'b0;
            ue_s = 1'b0;
         end
      endcase
   end

   // Stage 2: result registers, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_chk_r   <= {CHK_W{1'b0}};
         out_ce_r    <= 1'b0;
         out_ue_r    <= 1'b0;
      end else if (s2_free_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_data_r <= corr_data_s;
            out_chk_r  <= s1_chk_r;
            out_ce_r   <= ce_s;
            out_ue_r   <= ue_s;
         end
      end
   end

   // Saturating error counters; a clear drops any same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_cnt_r <= {CNT_W{1'b0}};
         ue_cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         ce_cnt_r <= {CNT_W{1'b0}};
         ue_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (out_fire_s && out_ce_r && (ce_cnt_r != CNT_MAX_C)) begin
            ce_cnt_r <= ce_cnt_r + CNT_ONE_C;
         end
         if (out_fire_s && out_ue_r && (ue_cnt_r != CNT_MAX_C)) begin
            ue_cnt_r <= ue_cnt_r + CNT_ONE_C;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_chk   = out_chk_r;
   assign bus.out_ce    = out_ce_r;
   assign bus.out_ue    = out_ue_r;
   assign ce_cnt        = ce_cnt_r;
   assign ue_cnt        = ue_cnt_r;

endmodule

// File: tb/tb_secded_pipe_codec.sv
// Directed self-checking bench for secded_pipe_codec (DATA_W=64, CNT_W=4).
module tb_secded_pipe_codec;
   import secded_pkg::*;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cnt_clr;
   logic [NW-1:0] ce_cnt;
   logic [NW-1:0] ue_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int exp_ce   = 0;
   int exp_ue   = 0;

   secded_pipe_codec_if #(.DATA_W(DW), .CHK_W(CW)) bus ();

   secded_pipe_codec #(.DATA_W(DW), .CHK_W(CW), .CNT_W(NW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .cnt_clr (cnt_clr),
      .ce_cnt  (ce_cnt),
      .ue_cnt  (ue_cnt)
   );

   always #5 clk = ~clk;

   // Mixed stream: mode, input data/check, expected data/check/ce/ue
   logic          st_mode  [8] = '{ENC, DEC, ENC, DEC, ENC, DEC, ENC, DEC};
   logic [63:0]   st_in_d  [8] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0,
                                   64'h0, 64'h2, 64'h2, 64'h1};
   logic [7:0]    st_in_c  [8] = '{8'hA5, 8'h83, 8'h00, 8'h83, 8'hFF, 8'h83, 8'h11, 8'h87};
   logic [63:0]   st_exp_d [8] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h1,
                                   64'h0, 64'h2, 64'h2, 64'h1};
   logic [7:0]    st_exp_c [8] = '{8'h83, 8'h00, 8'hC7, 8'h83, 8'h00, 8'h06, 8'h85, 8'h84};
   logic          st_exp_ce[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic          st_exp_ue[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic          rdy_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   logic          in_fire;
   logic          stalled;
   logic [63:0]   snap_d;
   logic [7:0]    snap_c;
   logic [1:0]    snap_f;
   int            widx;
   int            ridx;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic bump(input logic ce, input logic ue);
      if (ce && exp_ce < 15) exp_ce++;
      if (ue && exp_ue < 15) exp_ue++;
   endtask

   // One isolated beat with out_ready=1: checks latency, result and counters.
   task automatic do_beat(input string tag, input logic mode, input logic [63:0] d,
                          input logic [7:0] c, input logic [63:0] ed, input logic [7:0] ec,
                          input logic ece, input logic eue);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_mode   = mode;
      bus.in_data   = d;
      bus.in_chk    = c;
      check_eq({tag, "_inrdy"}, bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check_eq({tag, "_lat1"}, bus.out_valid, 0);
      @(posedge clk); #1;
      check_eq({tag, "_valid"}, bus.out_valid, 1);
      check_eq({tag, "_data"}, bus.out_data, ed);
      check_eq({tag, "_chk"}, bus.out_chk, ec);
      check_eq({tag, "_ce"}, bus.out_ce, ece);
      check_eq({tag, "_ue"}, bus.out_ue, eue);
      @(posedge clk); #1;
      bump(ece, eue);
      check_eq({tag, "_cecnt"}, ce_cnt, exp_ce);
      check_eq({tag, "_uecnt"}, ue_cnt, exp_ue);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      cnt_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_mode   = ENC;
      bus.in_data   = '0;
      bus.in_chk    = '0;
      bus.out_ready = 1'b1;
      #3;
      check_eq("rst_inrdy", bus.in_ready, 1);
      check_eq("rst_outvld", bus.out_valid, 0);
      check_eq("rst_cecnt", ce_cnt, 0);
      check_eq("rst_uecnt", ue_cnt, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      do_beat("enc_lsb",   ENC, 64'h1, 8'h5A, 64'h1, 8'h83, 1'b0, 1'b0);
      do_beat("enc_msb",   ENC, 64'h8000_0000_0000_0000, 8'h00,
              64'h8000_0000_0000_0000, 8'hC7, 1'b0, 1'b0);
      do_beat("dec_clean", DEC, 64'h1, 8'h83, 64'h1, 8'h00, 1'b0, 1'b0);
      do_beat("dec_ce_b0", DEC, 64'h0, 8'h83, 64'h1, 8'h83, 1'b1, 1'b0);
      do_beat("dec_ce_b1", DEC, 64'h3, 8'h83, 64'h1, 8'h85, 1'b1, 1'b0);
      do_beat("dec_ue2",   DEC, 64'h2, 8'h83, 64'h2, 8'h06, 1'b0, 1'b1);
      do_beat("dec_cechk", DEC, 64'h1, 8'h87, 64'h1, 8'h84, 1'b1, 1'b0);
      do_beat("dec_cepar", DEC, 64'h1, 8'h03, 64'h1, 8'h80, 1'b1, 1'b0);
      do_beat("dec_uernge", DEC, 64'h0, 8'h7F, 64'h0, 8'hFF, 1'b0, 1'b1);
      do_beat("dec_ce_b63", DEC, 64'h0, 8'hC7, 64'h8000_0000_0000_0000, 8'hC7, 1'b1, 1'b0);
      check_eq("directed_cecnt", ce_cnt, 5);
      check_eq("directed_uecnt", ue_cnt, 2);

      // Stream with a 1,0,0,1 out_ready pattern
      widx    = 0;
      ridx    = 0;
      stalled = 1'b0;
      for (int cyc = 0; cyc < 200 && ridx < 8; cyc++) begin
         if (stalled) begin
            check_eq("stall_valid", bus.out_valid, 1);
            check_eq("stall_data", bus.out_data, snap_d);
            check_eq("stall_chk", bus.out_chk, snap_c);
            check_eq("stall_flags", {bus.out_ce, bus.out_ue}, snap_f);
         end
         bus.out_ready = rdy_pat[cyc % 4];
         if (widx < 8) begin
            bus.in_valid = 1'b1;
            bus.in_mode  = st_mode[widx];
            bus.in_data  = st_in_d[widx];
            bus.in_chk   = st_in_c[widx];
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         in_fire = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            check_eq($sformatf("st%0d_data", ridx), bus.out_data, st_exp_d[ridx]);
            check_eq($sformatf("st%0d_chk", ridx), bus.out_chk, st_exp_c[ridx]);
            check_eq($sformatf("st%0d_flags", ridx), {bus.out_ce, bus.out_ue},
                     {st_exp_ce[ridx], st_exp_ue[ridx]});
            bump(st_exp_ce[ridx], st_exp_ue[ridx]);
            ridx++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         snap_d  = bus.out_data;
         snap_c  = bus.out_chk;
         snap_f  = {bus.out_ce, bus.out_ue};
         @(posedge clk); #1;
         if (in_fire) widx++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check_eq("stream_count", ridx, 8);
      @(posedge clk); #1;
      check_eq("stream_nodup", bus.out_valid, 0);
      check_eq("stream_cecnt", ce_cnt, 7);
      check_eq("stream_uecnt", ue_cnt, 3);

      // Clear, then saturate the 4-bit CE counter
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      exp_ce  = 0;
      exp_ue  = 0;
      check_eq("clr_cecnt", ce_cnt, 0);
      check_eq("clr_uecnt", ue_cnt, 0);
      for (int n = 0; n < 16; n++) begin
         do_beat($sformatf("sat%0d", n), DEC, 64'h0, 8'h83, 64'h1, 8'h83, 1'b1, 1'b0);
      end
      check_eq("sat_hold", ce_cnt, 15);

      // Clear coinciding with a CE handshake wins
      bus.in_valid = 1'b1;
      bus.in_mode  = DEC;
      bus.in_data  = 64'h0;
      bus.in_chk   = 8'h83;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("clrce_valid", bus.out_valid, 1);
      check_eq("clrce_ce", bus.out_ce, 1);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      exp_ce  = 0;
      check_eq("clrce_cecnt", ce_cnt, 0);

      // Reset with both stages full
      do_beat("pre_rst", DEC, 64'h0, 8'h83, 64'h1, 8'h83, 1'b1, 1'b0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_mode   = ENC;
      bus.in_data   = 64'h1;
      @(posedge clk); #1;
      bus.in_data   = 64'h2;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check_eq("full_inrdy", bus.in_ready, 0);
      check_eq("full_outvld", bus.out_valid, 1);
      check_eq("full_cecnt", ce_cnt, 1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_ce = 0;
      exp_ue = 0;
      check_eq("midrst_outvld", bus.out_valid, 0);
      check_eq("midrst_inrdy", bus.in_ready, 1);
      check_eq("midrst_cecnt", ce_cnt, 0);
      check_eq("midrst_data", bus.out_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_beat("post_rst", ENC, 64'h8000_0000_0000_0000, 8'h3C,
              64'h8000_0000_0000_0000, 8'hC7, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
